vram_access_ctrl: RTL and testbench

- Owns both ports of the dual-port video RAM (20-bit address, 24-bit pixel).
- Write port: round-robin arbiter between an external host pixel-write stream (valid/ready) and an internal framebuffer clear engine.
- Read port: scanout sequencer that walks the framebuffer linearly, one address per enabled cycle, and flags returned pixels for the display pipeline.

---
 rtl/vram_access_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_vram_access_ctrl.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_access_ctrl.sv
// -----------------------------------------------------------------------------
// vram_access_ctrl
//
// Owns both ports of a dual-port video RAM.
//   Write port: round-robin arbiter between the host pixel-write stream
//               (valid/ready) and an internal framebuffer clear engine.
//   Read port : scanout sequencer walking the framebuffer linearly, one
//               address per scan_en cycle, flagging returned pixels.
//
// Optional feature macro: VRAM_CLEAR_EN
//   defined   -> clear engine + round-robin arbitration present.
//   undefined -> no clear logic; clear_busy/clear_done tied 0, host_ready
//                tied 1, host owns the write port every cycle.
//
// Ports:
//   clk, rst                 system clock, async active-high reset
//   host_valid/addr/data     host write request
//   host_ready               combinational grant to the host
//   host_err                 1-cycle pulse: accepted write was out of range
//   clear_start/clear_color  start a framebuffer fill with the given colour
//   clear_busy, clear_done   clear engine status / completion pulse
//   frame_start, scan_en     start scanout / per-cycle read pacing
//   scan_busy, pixel_valid   scanout status / RAM dataOut is a scan pixel
//   frame_done               pulse with the last pixel_valid of a frame
//   vram_we/waddr/wdata      registered VRAM write port
//   vram_re/raddr            registered VRAM read port
// -----------------------------------------------------------------------------
module vram_access_ctrl #(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 24,
  parameter int FB_SIZE = 786432
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_valid,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_data,
  output logic              host_ready,
  output logic              host_err,
  input  logic              clear_start,
  input  logic [DATA_W-1:0] clear_color,
  output logic              clear_busy,
  output logic              clear_done,
  input  logic              frame_start,
  input  logic              scan_en,
  output logic              scan_busy,
  output logic              pixel_valid,
  output logic              frame_done,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_waddr,
  output logic [DATA_W-1:0] vram_wdata,
  output logic              vram_re,
  output logic [ADDR_W-1:0] vram_raddr
);

  // Last legal pixel address; all range checks compare against this so the
  // counters never depend on natural wrap-around.
  localparam logic [ADDR_W-1:0] FB_LAST = ADDR_W'(FB_SIZE - 1);

  // ---------------------------------------------------------------------------
  // Write path: arbitration and clear engine
  // ---------------------------------------------------------------------------
  logic              grant_host;
  logic              grant_clear;
  logic              host_in_range;
  logic [ADDR_W-1:0] clear_ctr;
  logic [DATA_W-1:0] clear_color_q;

  assign host_in_range = (host_addr <= FB_LAST);

`ifdef VRAM_CLEAR_EN
  typedef enum logic {CLR_IDLE, CLR_RUN}        clr_state_t;
  typedef enum logic {GRANT_HOST, GRANT_CLEAR}  grant_t;

  clr_state_t clr_state;
  clr_state_t clr_state_nxt;
  grant_t     last_grant;
  logic       clear_last;

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) clr_state <= CLR_IDLE;
    else     clr_state <= clr_state_nxt;
  end

  // NOTE: every signal written in a combinational block gets a default first,
  // otherwise paths that skip the assignment infer a latch.
  always_comb begin
    clr_state_nxt = clr_state;
    unique case (clr_state)
      CLR_IDLE: if (clear_start) clr_state_nxt = CLR_RUN;
      CLR_RUN:  if (clear_last)  clr_state_nxt = CLR_IDLE;
      default:                   clr_state_nxt = CLR_IDLE;
    endcase
  end

  // The clear engine requests every busy cycle; the host only loses when it
  // had the previous grant, which yields strict alternation under contention.
  always_comb begin
    clear_busy  = (clr_state == CLR_RUN);
    host_ready  = !clear_busy || (last_grant == GRANT_CLEAR);
    grant_host  = host_valid && host_ready;
    grant_clear = clear_busy && !grant_host;
    clear_last  = grant_clear && (clear_ctr == FB_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant    <= GRANT_CLEAR;
      clear_ctr     <= '0;
      clear_color_q <= '0;
      clear_done    <= 1'b0;
    end else begin
      if (grant_host)       last_grant <= GRANT_HOST;
      else if (grant_clear) last_grant <= GRANT_CLEAR;

      if (clr_state == CLR_IDLE && clear_start) begin
        clear_ctr     <= '0;
        clear_color_q <= clear_color;
      end else if (grant_clear) begin
        clear_ctr <= clear_ctr + 1'b1;
      end

      // Aligned with the final clear vram_we, which also appears next cycle.
      clear_done <= clear_last;
    end
  end
`else
  // Clear engine absent: the host owns the write port unconditionally.
  logic unused_clear_inputs;

  assign unused_clear_inputs = ^{clear_start, clear_color};
  assign clear_busy          = 1'b0;
  assign clear_done          = 1'b0;
  assign host_ready          = 1'b1;
  assign grant_host          = host_valid;
  assign grant_clear         = 1'b0;
  assign clear_ctr           = '0;
  assign clear_color_q       = '0;
`endif

  // Registered VRAM write port. Out-of-range host writes are accepted but
  // dropped, reporting host_err instead of a write strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vram_we    <= 1'b0;
      vram_waddr <= '0;
      vram_wdata <= '0;
      host_err   <= 1'b0;
    end else begin
      vram_we  <= (grant_host && host_in_range) || grant_clear;
      host_err <= grant_host && !host_in_range;
      if (grant_clear) begin
        vram_waddr <= clear_ctr;
        vram_wdata <= clear_color_q;
      end else if (grant_host && host_in_range) begin
        vram_waddr <= host_addr;
        vram_wdata <= host_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read path: scanout sequencer
  // ---------------------------------------------------------------------------
  // SCAN_DRAIN: the last read is on the RAM port; SCAN_LAST: its pixel is
  // returning. Both keep scan_busy high until the final pixel_valid is done.
  typedef enum logic [1:0] {SCAN_IDLE, SCAN_RUN, SCAN_DRAIN, SCAN_LAST} scan_state_t;

  scan_state_t       scan_state;
  scan_state_t       scan_state_nxt;
  logic [ADDR_W-1:0] scan_ctr;
  logic              scan_issue;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) scan_state <= SCAN_IDLE;
    else     scan_state <= scan_state_nxt;
  end

  always_comb begin
    scan_state_nxt = scan_state;
    unique case (scan_state)
      SCAN_IDLE:  if (frame_start) scan_state_nxt = SCAN_RUN;
      SCAN_RUN:   if (scan_en && scan_ctr == FB_LAST) scan_state_nxt = SCAN_DRAIN;
      SCAN_DRAIN: scan_state_nxt = SCAN_LAST;
      SCAN_LAST:  scan_state_nxt = SCAN_IDLE;
      default:    scan_state_nxt = SCAN_IDLE;
    endcase
  end

  always_comb begin
    scan_busy  = (scan_state != SCAN_IDLE);
    scan_issue = (scan_state == SCAN_RUN) && scan_en;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_ctr    <= '0;
      vram_re     <= 1'b0;
      vram_raddr  <= '0;
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      if (scan_state == SCAN_IDLE && frame_start) scan_ctr <= '0;
      else if (scan_issue)                        scan_ctr <= scan_ctr + 1'b1;

      vram_re <= scan_issue;
      if (scan_issue) vram_raddr <= scan_ctr;

      // RAM read latency is one cycle.
      pixel_valid <= vram_re;
      frame_done  <= (scan_state == SCAN_DRAIN);
    end
  end

endmodule

// File: tb/tb_vram_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vram_access_ctrl
//
// Self-checking bench for vram_access_ctrl with FB_SIZE=16. Combines a table
// of single host writes, hand-written multi-cycle sequences (clear, contended
// clear, scanout with pacing gap, async reset mid-clear) and randomized
// traffic, all compared every cycle against a transaction-level model.
// Clear-specific sequences follow the VRAM_CLEAR_EN macro.
// -----------------------------------------------------------------------------
module tb_vram_access_ctrl;

  localparam int AW = 20;
  localparam int DW = 24;
  localparam int FB = 16;
`ifdef VRAM_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          host_valid;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_data;
  logic          host_ready;
  logic          host_err;
  logic          clear_start;
  logic [DW-1:0] clear_color;
  logic          clear_busy;
  logic          clear_done;
  logic          frame_start;
  logic          scan_en;
  logic          scan_busy;
  logic          pixel_valid;
  logic          frame_done;
  logic          vram_we;
  logic [AW-1:0] vram_waddr;
  logic [DW-1:0] vram_wdata;
  logic          vram_re;
  logic [AW-1:0] vram_raddr;

  vram_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .FB_SIZE(FB)) dut (
    .clk         (clk),
    .rst         (rst),
    .host_valid  (host_valid),
    .host_addr   (host_addr),
    .host_data   (host_data),
    .host_ready  (host_ready),
    .host_err    (host_err),
    .clear_start (clear_start),
    .clear_color (clear_color),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done),
    .frame_start (frame_start),
    .scan_en     (scan_en),
    .scan_busy   (scan_busy),
    .pixel_valid (pixel_valid),
    .frame_done  (frame_done),
    .vram_we     (vram_we),
    .vram_waddr  (vram_waddr),
    .vram_wdata  (vram_wdata),
    .vram_re     (vram_re),
    .vram_raddr  (vram_raddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: clear engine as "next address to fill", scanout as
  // "next address to read" plus a tail of busy cycles after the last read.
  // ---------------------------------------------------------------------------
  bit            c_active, last_clear;
  int            c_next;
  logic [DW-1:0] c_color;
  bit            s_active;
  int            s_next, s_tail;

  bit            e_we, e_err, e_cdone, e_re, e_pv, e_fd;
  logic [AW-1:0] e_waddr, e_raddr;
  logic [DW-1:0] e_wdata;

  function automatic bit m_host_ready();
    return !CLR || !c_active || last_clear;
  endfunction

  task automatic model_reset();
    c_active = 0; last_clear = 1; c_next = 0; c_color = '0;
    s_active = 0; s_next = 0; s_tail = 0;
    e_we = 0; e_err = 0; e_cdone = 0; e_re = 0; e_pv = 0; e_fd = 0;
    e_waddr = '0; e_raddr = '0; e_wdata = '0;
  endtask

  // Advances the model across one clock edge using the inputs now applied.
  task automatic model_edge();
    bit gh, gc, n_pv, n_fd;
    gh = host_valid && m_host_ready();
    gc = CLR && c_active && !gh;
    e_we  = (gh && host_addr < FB) || gc;
    e_err = gh && host_addr >= FB;
    if (gc) begin
      e_waddr = AW'(c_next);
      e_wdata = c_color;
    end else if (gh && host_addr < FB) begin
      e_waddr = host_addr;
      e_wdata = host_data;
    end
    e_cdone = 0;
    if (gh) last_clear = 0;
    if (gc) begin
      last_clear = 1;
      if (c_next == FB - 1) begin
        c_active = 0;
        e_cdone  = 1;
      end
      c_next++;
    end else if (CLR && !c_active && clear_start) begin
      c_active = 1;
      c_next   = 0;
      c_color  = clear_color;
    end

    n_pv = e_re;
    n_fd = e_re && (e_raddr == AW'(FB - 1));
    e_re = 0;
    if (s_active) begin
      if (scan_en) begin
        e_re    = 1;
        e_raddr = AW'(s_next);
        if (s_next == FB - 1) begin
          s_active = 0;
          s_tail   = 2;
        end
        s_next++;
      end
    end else if (s_tail > 0) begin
      s_tail--;
    end else if (frame_start) begin
      s_active = 1;
      s_next   = 0;
    end
    e_pv = n_pv;
    e_fd = n_fd;
  endtask

  task automatic compare_outputs();
    check("vram_we", vram_we, e_we);
    if (e_we) begin
      check("vram_waddr", vram_waddr, e_waddr);
      check("vram_wdata", vram_wdata, e_wdata);
    end
    check("host_err", host_err, e_err);
    check("host_ready", host_ready, m_host_ready());
    check("clear_busy", clear_busy, c_active);
    check("clear_done", clear_done, e_cdone);
    check("vram_re", vram_re, e_re);
    if (e_re) check("vram_raddr", vram_raddr, e_raddr);
    check("pixel_valid", pixel_valid, e_pv);
    check("frame_done", frame_done, e_fd);
    check("scan_busy", scan_busy, s_active || s_tail > 0);
  endtask

  // One clock: model advances on the applied inputs, DUT sampled 1 ns later.
  task automatic cycle();
    #1;
    model_edge();
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic check_reset_values();
    check("rst_vram_we", vram_we, 0);
    check("rst_vram_waddr", vram_waddr, 0);
    check("rst_vram_wdata", vram_wdata, 0);
    check("rst_host_err", host_err, 0);
    check("rst_host_ready", host_ready, 1);
    check("rst_clear_busy", clear_busy, 0);
    check("rst_clear_done", clear_done, 0);
    check("rst_vram_re", vram_re, 0);
    check("rst_vram_raddr", vram_raddr, 0);
    check("rst_pixel_valid", pixel_valid, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_scan_busy", scan_busy, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Host write vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            exp_we;
    bit            exp_err;
  } hvec_t;

  hvec_t tbl[6];

  int cnt, dones, n_clear, n_host, n_hs, n_re, n_pv, n_fd, gap;
  bit have_prev, prev_hr, done_seen;

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{20'd3,       24'hABCDEF, 1'b1, 1'b0};
    tbl[1] = '{20'd20,      24'h111111, 1'b0, 1'b1};
    tbl[2] = '{20'd15,      24'h00FF00, 1'b1, 1'b0};
    tbl[3] = '{20'd16,      24'h222222, 1'b0, 1'b1};
    tbl[4] = '{20'd0,       24'hFFFFFF, 1'b1, 1'b0};
    tbl[5] = '{20'hFFFFF,   24'h333333, 1'b0, 1'b1};

    rst = 1'b1;
    host_valid = 0; host_addr = '0; host_data = '0;
    clear_start = 0; clear_color = '0;
    frame_start = 0; scan_en = 0;
    model_reset();
    @(posedge clk);
    #1;
    check_reset_values();
    rst = 1'b0;
    cycle();

    // ---- table: single host writes from idle ----
    for (int i = 0; i < 6; i++) begin
      host_valid = 1; host_addr = tbl[i].addr; host_data = tbl[i].data;
      cycle();
      host_valid = 0;
      check("tbl_we", vram_we, tbl[i].exp_we);
      check("tbl_err", host_err, tbl[i].exp_err);
      if (tbl[i].exp_we) begin
        check("tbl_waddr", vram_waddr, tbl[i].addr);
        check("tbl_wdata", vram_wdata, tbl[i].data);
      end
      cycle();
      check("tbl_no_extra_we", vram_we, 0);
      check("tbl_err_pulse", host_err, 0);
    end

`ifdef VRAM_CLEAR_EN
    // ---- clear with host idle: 16 consecutive writes, done with addr 15 ----
    clear_color = 24'h000000; clear_start = 1;
    cycle();
    clear_start = 0; clear_color = 24'h5A5A5A;
    check("clr_busy_rise", clear_busy, 1);
    cnt = 0; dones = 0;
    for (int i = 0; i < 40 && dones == 0; i++) begin
      cycle();
      check("clr_consec_we", vram_we, 1);
      if (vram_we) begin
        check("clr_addr", vram_waddr, cnt);
        check("clr_data", vram_wdata, 0);
        cnt++;
      end
      if (clear_done) begin
        dones++;
        check("clr_done_addr", vram_waddr, 15);
        check("clr_busy_fall", clear_busy, 0);
      end
    end
    check("clr_count", cnt, 16);
    check("clr_done_seen", dones, 1);
    cycle();
    check("clr_done_pulse", clear_done, 0);

    // ---- clear contended by a continuous host stream ----
    clear_color = 24'h123456; clear_start = 1;
    cycle();
    clear_start = 0; host_valid = 1;
    n_clear = 0; n_host = 0; n_hs = 0; have_prev = 0; prev_hr = 0; done_seen = 0;
    for (int i = 0; i < 80 && !done_seen; i++) begin
      host_addr = AW'(i % FB);
      host_data = 24'hF00000 | DW'(i);
      if (host_ready) n_hs++;
      if (clear_busy) begin
        if (have_prev) check("hr_toggle", host_ready, !prev_hr);
        prev_hr   = host_ready;
        have_prev = 1;
      end
      cycle();
      if (vram_we) begin
        if (vram_wdata == 24'h123456) n_clear++;
        else                          n_host++;
      end
      if (clear_done) done_seen = 1;
    end
    host_valid = 0;
    check("mix_done_seen", done_seen, 1);
    check("mix_clear_writes", n_clear, 16);
    check("mix_host_handshakes", n_hs, 16);
    check("mix_host_writes", n_host, n_hs);
    cycle();
`else
    // ---- no clear engine: clear_start has no effect, host always ready ----
    host_valid = 1; cnt = 0;
    for (int i = 0; i < 20; i++) begin
      clear_start = (i % 2 == 0); clear_color = 24'h0F0F0F;
      host_addr = AW'(i % FB); host_data = DW'(i);
      check("nc_host_ready", host_ready, 1);
      cycle();
      check("nc_clear_busy", clear_busy, 0);
      check("nc_clear_done", clear_done, 0);
      if (vram_we) cnt++;
    end
    clear_start = 0; host_valid = 0;
    check("nc_host_writes", cnt, 20);
    cycle();
`endif

    // ---- scanout with a 3-cycle scan_en drop and an ignored frame_start ----
    frame_start = 1; scan_en = 1;
    cycle();
    frame_start = 0;
    check("scan_busy_rise", scan_busy, 1);
    n_re = 0; n_pv = 0; n_fd = 0; gap = 0;
    for (int i = 0; i < 60; i++) begin
      scan_en     = !(i >= 6 && i < 9);
      frame_start = (i == 10);
      cycle();
      if (vram_re) begin
        check("scan_raddr", vram_raddr, n_re);
        n_re++;
      end
      if (pixel_valid) n_pv++;
      else if (scan_busy && n_pv > 0) gap++;
      if (frame_done) begin
        n_fd++;
        check("fd_on_16th_pv", n_pv, 16);
        check("fd_with_pv", pixel_valid, 1);
        check("fd_busy_high", scan_busy, 1);
      end
      if (!scan_busy) break;
    end
    frame_start = 0; scan_en = 0;
    check("scan_reads", n_re, 16);
    check("scan_pixels", n_pv, 16);
    check("scan_frame_done", n_fd, 1);
    check("scan_gap", gap, 3);
    check("scan_ended", scan_busy, 0);

`ifdef VRAM_CLEAR_EN
    // ---- async reset mid-clear (and mid-scan) abandons without done ----
    clear_color = 24'h777777; clear_start = 1; frame_start = 1; scan_en = 1;
    cycle();
    clear_start = 0; frame_start = 0;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (vram_we && vram_waddr == 7) break;
    end
    check("rst_reached_addr7", vram_waddr, 7);
    #2 rst = 1'b1;
    #1;
    check_reset_values();
    model_reset();
    @(posedge clk);
    #1;
    compare_outputs();
    rst = 1'b0;
    scan_en = 0;
    for (int i = 0; i < 25; i++) begin
      cycle();
      check("no_done_after_rst", clear_done, 0);
    end
`endif

    // ---- randomized traffic against the model ----
    for (int i = 0; i < 800; i++) begin
      host_valid  = ($urandom_range(0, 9) < 6);
      host_addr   = AW'($urandom_range(0, 23));
      host_data   = DW'($urandom);
      clear_start = ($urandom_range(0, 39) == 0);
      clear_color = DW'($urandom);
      frame_start = ($urandom_range(0, 29) == 0);
      scan_en     = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
